// File: rtl/regfile_writeback_queue_if.sv
// Enqueue bus for regfile_writeback_queue: the valid/ready handshake that carries
// register writeback requests from the functional units into the queue.
interface regfile_writeback_queue_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_reg;
    logic [DATA_WIDTH-1:0] in_data;

    // Producer side (execute/memory stages).
    modport master (
        output in_valid,
        output in_reg,
        output in_data,
        input  in_ready
    );

    // Consumer side (the writeback queue).
    modport slave (
        input  in_valid,
        input  in_reg,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue: FIFO of pending register writebacks that owns the register
// file's single write port and drains one entry per cycle unless wr_stall is high.
// Both read ports report whether their address has a write still in flight.
// Optional feature: define WBQ_FORWARD_EN to build read-data forwarding muxes
// (youngest queue entry, then output stage, then raw regfile data). Without it the
// read data passes straight through and pend_hitA/B serve as stall flags.
module regfile_writeback_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                        clock,
    input  logic                        ctrl_reset,
    regfile_writeback_queue_if.slave    wb_in,
    input  logic                        wr_stall,
    output logic                        ctrl_writeEnable,
    output logic [ADDR_WIDTH-1:0]       ctrl_writeReg,
    output logic [DATA_WIDTH-1:0]       data_writeReg,
    input  logic [ADDR_WIDTH-1:0]       ctrl_readRegA,
    input  logic [DATA_WIDTH-1:0]       data_regfileA,
    output logic [DATA_WIDTH-1:0]       data_readRegA,
    output logic                        pend_hitA,
    input  logic [ADDR_WIDTH-1:0]       ctrl_readRegB,
    input  logic [DATA_WIDTH-1:0]       data_regfileB,
    output logic [DATA_WIDTH-1:0]       data_readRegB,
    output logic                        pend_hitB,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Queue storage, indexed by physical slot.
    logic [ADDR_WIDTH-1:0] r_mem_reg  [DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];

    // Pointers wrap naturally modulo DEPTH because DEPTH is a power of two.
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_count;

    // Output stage driving the register file write port.
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_wr_reg;
    logic [DATA_WIDTH-1:0] r_wr_data;

    logic                  w_in_ready;
    logic                  w_push;
    logic                  w_pop;
    logic [DEPTH-1:0]      w_slot_valid;
    logic [DEPTH-1:0]      w_match_a;
    logic [DEPTH-1:0]      w_match_b;
    logic                  w_out_hit_a;
    logic                  w_out_hit_b;

    // Readiness uses the pre-edge count only, so a full queue refuses a push even on
    // an edge where it also pops.
    assign w_in_ready     = (r_count < FULL_CNT);
    assign wb_in.in_ready = w_in_ready;

    // Writes to register 0 are handshaken but never stored.
    assign w_push = wb_in.in_valid & w_in_ready & (wb_in.in_reg != '0);
    assign w_pop  = ~wr_stall & (r_count != '0);

    // Pointer and occupancy bookkeeping.
    // NOTE: every clocked block uses non-blocking assignments so all registers sample
    // pre-edge values; blocking here would let later statements see updated state.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage write.
    // NOTE: the storage array has no reset; an entry is only ever read while the
    // count says it is valid, so clearing it would cost reset fan-out for nothing.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_reg[r_wr_ptr]  <= wb_in.in_reg;
            r_mem_data[r_wr_ptr] <= wb_in.in_data;
        end
    end

    // Output stage: load the head on a pop, otherwise drop enable and hold address/data.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            r_we      <= 1'b0;
            r_wr_reg  <= '0;
            r_wr_data <= '0;
        end else if (w_pop) begin
            r_we      <= 1'b1;
            r_wr_reg  <= r_mem_reg[r_rd_ptr];
            r_wr_data <= r_mem_data[r_rd_ptr];
        end else begin
            r_we      <= 1'b0;
        end
    end

    // Mark which physical slots hold live entries: a slot is live when its age
    // offset from the read pointer is below the current count.
    // NOTE: each combinational block assigns its outputs a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        w_slot_valid = '0;
        for (int j = 0; j < DEPTH; j++) begin
            w_slot_valid[j] = ({1'b0, PTR_W'(j) - r_rd_ptr} < r_count);
        end
    end

    // Per-slot address match for both read ports; register 0 never matches.
    always_comb begin
        w_match_a = '0;
        w_match_b = '0;
        for (int j = 0; j < DEPTH; j++) begin
            w_match_a[j] = w_slot_valid[j] & (ctrl_readRegA != '0) &
                           (r_mem_reg[j] == ctrl_readRegA);
            w_match_b[j] = w_slot_valid[j] & (ctrl_readRegB != '0) &
                           (r_mem_reg[j] == ctrl_readRegB);
        end
    end

    // The output stage is still pending while it is driving the write port.
    assign w_out_hit_a = r_we & (ctrl_readRegA != '0) & (r_wr_reg == ctrl_readRegA);
    assign w_out_hit_b = r_we & (ctrl_readRegB != '0) & (r_wr_reg == ctrl_readRegB);

    assign pend_hitA = (|w_match_a) | w_out_hit_a;
    assign pend_hitB = (|w_match_b) | w_out_hit_b;

`ifdef WBQ_FORWARD_EN
    // Walk live entries oldest to youngest so the youngest match is the one kept;
    // fall back to the output stage, then to the raw regfile data.
    function automatic logic [DATA_WIDTH-1:0] youngest_data(
        input logic [DEPTH-1:0]      match,
        input logic [PTR_W-1:0]      rd_ptr,
        input logic                  out_hit,
        input logic [DATA_WIDTH-1:0] out_data,
        input logic [DATA_WIDTH-1:0] raw_data
    );
        logic [DATA_WIDTH-1:0] result;
        logic [PTR_W-1:0]      slot;
        result = out_hit ? out_data : raw_data;
        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_ptr + PTR_W'(i);
            if (match[slot]) begin
                result = r_mem_data[slot];
            end
        end
        return result;
    endfunction

    // Forwarded read data for both ports.
    always_comb begin
        data_readRegA = youngest_data(w_match_a, r_rd_ptr, w_out_hit_a, r_wr_data,
                                      data_regfileA);
        data_readRegB = youngest_data(w_match_b, r_rd_ptr, w_out_hit_b, r_wr_data,
                                      data_regfileB);
    end
`else
    // No forwarding: consumers stall on pend_hitA/B and read the regfile directly.
    assign data_readRegA = data_regfileA;
    assign data_readRegB = data_regfileB;
`endif

    assign ctrl_writeEnable = r_we;
    assign ctrl_writeReg    = r_wr_reg;
    assign data_writeReg    = r_wr_data;
    assign count            = r_count;

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue: inputs change and outputs are sampled
// on the falling clock edge, away from the rising edge where state updates.
module tb_regfile_writeback_queue;

    localparam int DEPTH      = 4;
    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 32;

    logic                  clock;
    logic                  ctrl_reset;
    logic                  wr_stall;
    logic                  ctrl_writeEnable;
    logic [ADDR_WIDTH-1:0] ctrl_writeReg;
    logic [DATA_WIDTH-1:0] data_writeReg;
    logic [ADDR_WIDTH-1:0] ctrl_readRegA;
    logic [DATA_WIDTH-1:0] data_regfileA;
    logic [DATA_WIDTH-1:0] data_readRegA;
    logic                  pend_hitA;
    logic [ADDR_WIDTH-1:0] ctrl_readRegB;
    logic [DATA_WIDTH-1:0] data_regfileB;
    logic [DATA_WIDTH-1:0] data_readRegB;
    logic                  pend_hitB;
    logic [$clog2(DEPTH):0] count;

    int n_vec;
    int n_err;

    regfile_writeback_queue_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) wb_if ();

    regfile_writeback_queue #(
        .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .wb_in            (wb_if),
        .wr_stall         (wr_stall),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .data_regfileA    (data_regfileA),
        .data_readRegA    (data_readRegA),
        .pend_hitA        (pend_hitA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_regfileB    (data_regfileB),
        .data_readRegB    (data_readRegB),
        .pend_hitB        (pend_hitB),
        .count            (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Present one request for exactly one rising edge, then withdraw it.
    task automatic push(input logic [ADDR_WIDTH-1:0] r, input logic [DATA_WIDTH-1:0] d);
        wb_if.in_valid = 1'b1;
        wb_if.in_reg   = r;
        wb_if.in_data  = d;
        @(negedge clock);
        wb_if.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        ctrl_reset = 1'b0;
        repeat (2) @(negedge clock);
        n_vec++;
        if (ctrl_writeEnable !== 1'b0) begin
            n_err++; $display("FAIL reset_we: got %b expected 0", ctrl_writeEnable);
        end
        n_vec++;
        if (count !== 3'd0) begin
            n_err++; $display("FAIL reset_count: got %0d expected 0", count);
        end
        n_vec++;
        if (wb_if.in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready: got %b expected 1", wb_if.in_ready);
        end
        n_vec++;
        if (ctrl_writeReg !== 5'd0) begin
            n_err++; $display("FAIL reset_wreg: got %0d expected 0", ctrl_writeReg);
        end
        ctrl_reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_single_write();
        wr_stall      = 1'b0;
        ctrl_readRegA = 5'd5;
        data_regfileA = 32'h0000_0005;
        push(5'd5, 32'hDEAD_BEEF);
        // after edge 0: held in the queue
        n_vec++;
        if (count !== 3'd1 || ctrl_writeEnable !== 1'b0) begin
            n_err++; $display("FAIL single_e0: got count=%0d we=%b expected count=1 we=0",
                              count, ctrl_writeEnable);
        end
        @(negedge clock);
        // after edge 1: on the write port
        n_vec++;
        if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd5 || data_writeReg !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL single_e1: got we=%b reg=%0d data=%h expected we=1 reg=5 data=deadbeef",
                              ctrl_writeEnable, ctrl_writeReg, data_writeReg);
        end
        n_vec++;
        if (pend_hitA !== 1'b1) begin
            n_err++; $display("FAIL single_out_hit: got %b expected 1", pend_hitA);
        end
`ifdef WBQ_FORWARD_EN
        n_vec++;
        if (data_readRegA !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL single_out_fwd: got %h expected deadbeef", data_readRegA);
        end
`endif
        @(negedge clock);
        // after edge 2: committed, idle
        n_vec++;
        if (ctrl_writeEnable !== 1'b0 || count !== 3'd0) begin
            n_err++; $display("FAIL single_e2: got we=%b count=%0d expected we=0 count=0",
                              ctrl_writeEnable, count);
        end
        n_vec++;
        if (pend_hitA !== 1'b0) begin
            n_err++; $display("FAIL single_e2_hit: got %b expected 0", pend_hitA);
        end
    endtask

    task automatic test_fill_drain();
        wr_stall = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            push(ADDR_WIDTH'(k), DATA_WIDTH'(k));
        end
        n_vec++;
        if (count !== 3'd4 || wb_if.in_ready !== 1'b0) begin
            n_err++; $display("FAIL full: got count=%0d ready=%b expected count=4 ready=0",
                              count, wb_if.in_ready);
        end
        // r9 offered while stalled and full
        wb_if.in_valid = 1'b1;
        wb_if.in_reg   = 5'd9;
        wb_if.in_data  = 32'h9;
        @(negedge clock);
        n_vec++;
        if (count !== 3'd4) begin
            n_err++; $display("FAIL full_refuse: got count=%0d expected 4", count);
        end
        // still offering r9 on the first draining edge: refused on pre-edge count
        wr_stall = 1'b0;
        @(negedge clock);
        wb_if.in_valid = 1'b0;
        n_vec++;
        if (count !== 3'd3 || ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd1 || data_writeReg !== 32'h1) begin
            n_err++; $display("FAIL drain_1: got count=%0d we=%b reg=%0d data=%h expected count=3 we=1 reg=1 data=1",
                              count, ctrl_writeEnable, ctrl_writeReg, data_writeReg);
        end
        for (int k = 2; k <= 4; k++) begin
            @(negedge clock);
            n_vec++;
            if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== ADDR_WIDTH'(k) || data_writeReg !== DATA_WIDTH'(k)) begin
                n_err++; $display("FAIL drain_%0d: got we=%b reg=%0d data=%h expected we=1 reg=%0d data=%0h",
                                  k, ctrl_writeEnable, ctrl_writeReg, data_writeReg, k, k);
            end
        end
        @(negedge clock);
        n_vec++;
        if (ctrl_writeEnable !== 1'b0 || count !== 3'd0) begin
            n_err++; $display("FAIL drain_done: got we=%b count=%0d expected we=0 count=0",
                              ctrl_writeEnable, count);
        end
    endtask

    task automatic test_forward();
        logic [DATA_WIDTH-1:0] exp_q, exp_out;
`ifdef WBQ_FORWARD_EN
        exp_q   = 32'h22;
        exp_out = 32'h22;
`else
        exp_q   = 32'h99;
        exp_out = 32'h99;
`endif
        wr_stall = 1'b1;
        push(5'd7, 32'h11);
        push(5'd7, 32'h22);
        ctrl_readRegA = 5'd7;
        ctrl_readRegB = 5'd8;
        data_regfileA = 32'h99;
        data_regfileB = 32'h55;
        #1;
        n_vec++;
        if (pend_hitA !== 1'b1 || pend_hitB !== 1'b0) begin
            n_err++; $display("FAIL fwd_hits: got A=%b B=%b expected A=1 B=0", pend_hitA, pend_hitB);
        end
        n_vec++;
        if (data_readRegB !== 32'h55) begin
            n_err++; $display("FAIL fwd_passB: got %h expected 00000055", data_readRegB);
        end
        n_vec++;
        if (data_readRegA !== exp_q) begin
            n_err++; $display("FAIL fwd_youngest: got %h expected %h", data_readRegA, exp_q);
        end
        wr_stall = 1'b0;
        @(negedge clock);
        // 0x11 on the output stage, 0x22 still queued: queue wins
        n_vec++;
        if (ctrl_writeEnable !== 1'b1 || data_writeReg !== 32'h11 || count !== 3'd1) begin
            n_err++; $display("FAIL fwd_drain1: got we=%b data=%h count=%0d expected we=1 data=11 count=1",
                              ctrl_writeEnable, data_writeReg, count);
        end
        n_vec++;
        if (data_readRegA !== exp_q || pend_hitA !== 1'b1) begin
            n_err++; $display("FAIL fwd_q_over_out: got data=%h hit=%b expected data=%h hit=1",
                              data_readRegA, pend_hitA, exp_q);
        end
        @(negedge clock);
        // only the output stage holds r7 now
        n_vec++;
        if (data_readRegA !== exp_out || pend_hitA !== 1'b1 || count !== 3'd0) begin
            n_err++; $display("FAIL fwd_out_only: got data=%h hit=%b count=%0d expected data=%h hit=1 count=0",
                              data_readRegA, pend_hitA, count, exp_out);
        end
        @(negedge clock);
        n_vec++;
        if (data_readRegA !== 32'h99 || pend_hitA !== 1'b0) begin
            n_err++; $display("FAIL fwd_retired: got data=%h hit=%b expected data=00000099 hit=0",
                              data_readRegA, pend_hitA);
        end
    endtask

    task automatic test_reg0();
        wr_stall      = 1'b0;
        ctrl_readRegA = 5'd0;
        data_regfileA = 32'h1234;
        push(5'd0, 32'hFFFF);
        n_vec++;
        if (count !== 3'd0 || ctrl_writeEnable !== 1'b0) begin
            n_err++; $display("FAIL r0_drop: got count=%0d we=%b expected count=0 we=0",
                              count, ctrl_writeEnable);
        end
        n_vec++;
        if (pend_hitA !== 1'b0 || data_readRegA !== 32'h1234) begin
            n_err++; $display("FAIL r0_read: got hit=%b data=%h expected hit=0 data=00001234",
                              pend_hitA, data_readRegA);
        end
        @(negedge clock);
        n_vec++;
        if (ctrl_writeEnable !== 1'b0 || ctrl_writeReg !== 5'd7) begin
            n_err++; $display("FAIL r0_no_write: got we=%b reg=%0d expected we=0 reg=7 (held)",
                              ctrl_writeEnable, ctrl_writeReg);
        end
    endtask

    task automatic test_reset_midstream();
        wr_stall = 1'b1;
        push(5'd10, 32'hA);
        push(5'd11, 32'hB);
        push(5'd12, 32'hC);
        n_vec++;
        if (count !== 3'd3) begin
            n_err++; $display("FAIL mid_fill: got count=%0d expected 3", count);
        end
        #2 ctrl_reset = 1'b0;
        #1;
        n_vec++;
        if (count !== 3'd0 || ctrl_writeEnable !== 1'b0 || ctrl_writeReg !== 5'd0 || data_writeReg !== 32'd0) begin
            n_err++; $display("FAIL mid_reset: got count=%0d we=%b reg=%0d data=%h expected all 0",
                              count, ctrl_writeEnable, ctrl_writeReg, data_writeReg);
        end
        @(negedge clock);
        ctrl_reset = 1'b1;
        wr_stall   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            n_vec++;
            if (ctrl_writeEnable !== 1'b0 || count !== 3'd0) begin
                n_err++; $display("FAIL mid_after_%0d: got we=%b count=%0d expected we=0 count=0",
                                  k, ctrl_writeEnable, count);
            end
        end
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        ctrl_reset     = 1'b1;
        wr_stall       = 1'b0;
        wb_if.in_valid = 1'b0;
        wb_if.in_reg   = '0;
        wb_if.in_data  = '0;
        ctrl_readRegA  = '0;
        ctrl_readRegB  = '0;
        data_regfileA  = '0;
        data_regfileB  = '0;
        @(negedge clock);
        test_reset();
        test_single_write();
        test_fill_drain();
        test_forward();
        test_reg0();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
